// File: rtl/radial_zone_cfg_writer_pkg.sv
`default_nettype none
// ============================================================================
// radial_zone_cfg_writer_pkg : address map, reset values and FSM states
// Rev 1.0
// ============================================================================
package radial_zone_cfg_writer_pkg;

  localparam int ZONE_IDX_W = 6;

  localparam logic [1:0] FLD_C    = 2'd0;
  localparam logic [1:0] FLD_Z    = 2'd1;
  localparam logic [1:0] FLD_ZMIN = 2'd2;
  localparam logic [1:0] FLD_RSQ  = 2'd3;

  localparam logic [7:0] ADDR_COL_CENTER = 8'hF0;
  localparam logic [7:0] ADDR_ROW_CENTER = 8'hF1;
  localparam logic [7:0] ADDR_CLR_ERR    = 8'hFE;
  localparam logic [7:0] ADDR_COMMIT     = 8'hFF;

  // Reset values make every zone a pass-through filter
  localparam logic [15:0] RST_C      = 16'h0000;
  localparam logic [15:0] RST_Z      = 16'hFFFF;
  localparam logic [15:0] RST_ZMIN   = 16'h0000;
  localparam logic [17:0] RST_RSQ    = 18'h3FFFF;
  localparam logic [15:0] RST_CENTER = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/radial_zone_cfg_regfile.sv
`default_nettype none
// ============================================================================
// radial_zone_cfg_regfile : shadow/active register pairs, loaded per field
// Rev 1.0
// ============================================================================
module radial_zone_cfg_regfile
  import radial_zone_cfg_writer_pkg::*;
#(
  parameter int NO_ZONES = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    zone_we_i,
  input  logic [ZONE_IDX_W-1:0]   zone_i,
  input  logic [1:0]              fld_i,
  input  logic                    col_we_i,
  input  logic                    row_we_i,
  input  logic [17:0]             data_i,
  input  logic                    apply_i,
  output logic [16*NO_ZONES-1:0]  c_o,
  output logic [16*NO_ZONES-1:0]  z_o,
  output logic [16*NO_ZONES-1:0]  z_min_o,
  output logic [18*NO_ZONES-1:0]  r_squared_o,
  output logic [15:0]             col_center_o,
  output logic [15:0]             row_center_o
);

  for (genvar zi = 0; zi < NO_ZONES; zi++) begin : g_zone
    logic        zone_sel;
    logic [15:0] c_sh_q, z_sh_q, zmin_sh_q;
    logic [17:0] rsq_sh_q;
    logic [15:0] c_act_q, z_act_q, zmin_act_q;
    logic [17:0] rsq_act_q;

    assign zone_sel = zone_we_i && (zone_i == ZONE_IDX_W'(zi));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        c_sh_q     <= RST_C;
        z_sh_q     <= RST_Z;
        zmin_sh_q  <= RST_ZMIN;
        rsq_sh_q   <= RST_RSQ;
        c_act_q    <= RST_C;
        z_act_q    <= RST_Z;
        zmin_act_q <= RST_ZMIN;
        rsq_act_q  <= RST_RSQ;
      end else begin
        if (zone_sel) begin
          case (fld_i)
            FLD_C:    c_sh_q    <= data_i[15:0];
            FLD_Z:    z_sh_q    <= data_i[15:0];
            FLD_ZMIN: zmin_sh_q <= data_i[15:0];
            default:  rsq_sh_q  <= data_i;
          endcase
        end
        if (apply_i) begin
          c_act_q    <= c_sh_q;
          z_act_q    <= z_sh_q;
          zmin_act_q <= zmin_sh_q;
          rsq_act_q  <= rsq_sh_q;
        end
      end
    end

    assign c_o[16*zi +: 16]         = c_act_q;
    assign z_o[16*zi +: 16]         = z_act_q;
    assign z_min_o[16*zi +: 16]     = zmin_act_q;
    assign r_squared_o[18*zi +: 18] = rsq_act_q;
  end

  logic [15:0] col_sh_q, row_sh_q, col_act_q, row_act_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_sh_q  <= RST_CENTER;
      row_sh_q  <= RST_CENTER;
      col_act_q <= RST_CENTER;
      row_act_q <= RST_CENTER;
    end else begin
      if (col_we_i) col_sh_q <= data_i[15:0];
      if (row_we_i) row_sh_q <= data_i[15:0];
      if (apply_i) begin
        col_act_q <= col_sh_q;
        row_act_q <= row_sh_q;
      end
    end
  end

  assign col_center_o = col_act_q;
  assign row_center_o = row_act_q;

endmodule
`default_nettype wire

// File: rtl/radial_zone_cfg_writer.sv
`default_nettype none
// ============================================================================
// radial_zone_cfg_writer : register decode and commit FSM for radial zones
// Rev 1.0
// ============================================================================
module radial_zone_cfg_writer
  import radial_zone_cfg_writer_pkg::*;
#(
  parameter int NO_ZONES          = 1,
  parameter int FRAME_START_GATED = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [7:0]              cfg_addr_i,
  input  logic [17:0]             cfg_data_i,
  input  logic                    valid_i,
  input  logic [15:0]             col_i,
  input  logic [15:0]             row_i,
  output logic [16*NO_ZONES-1:0]  c_o,
  output logic [16*NO_ZONES-1:0]  z_o,
  output logic [16*NO_ZONES-1:0]  z_min_o,
  output logic [18*NO_ZONES-1:0]  r_squared_o,
  output logic [15:0]             col_center_o,
  output logic [15:0]             row_center_o,
  output logic                    pending_o,
  output logic                    applied_o,
  output logic                    err_o
);

  localparam logic [ZONE_IDX_W-1:0] ZONE_LIMIT = ZONE_IDX_W'(NO_ZONES);

  state_t state_q;
  logic   cfg_ready_q, pending_q, applied_q, err_q;
  logic   accept, zone_hit, col_hit, row_hit, clr_hit, commit_hit, bad_hit;
  logic   frame_start;

  assign accept      = cfg_valid_i & cfg_ready_q;
  // Zone indices stop below 0xF0 even at 60 zones, so no overlap with specials
  assign zone_hit    = cfg_addr_i[7:2] < ZONE_LIMIT;
  assign col_hit     = cfg_addr_i == ADDR_COL_CENTER;
  assign row_hit     = cfg_addr_i == ADDR_ROW_CENTER;
  assign clr_hit     = cfg_addr_i == ADDR_CLR_ERR;
  assign commit_hit  = cfg_addr_i == ADDR_COMMIT;
  assign bad_hit     = ~(zone_hit | col_hit | row_hit | clr_hit | commit_hit);
  assign frame_start = valid_i & (col_i == 16'd0) & (row_i == 16'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cfg_ready_q <= 1'b1;
      pending_q   <= 1'b0;
      applied_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && commit_hit) begin
            state_q     <= ST_PENDING;
            cfg_ready_q <= 1'b0;
            pending_q   <= 1'b1;
          end
        end
        ST_PENDING: begin
          if ((FRAME_START_GATED == 0) || frame_start) begin
            state_q   <= ST_APPLY;
            pending_q <= 1'b0;
            applied_q <= 1'b1;
          end
        end
        ST_APPLY: begin
          state_q     <= ST_IDLE;
          applied_q   <= 1'b0;
          cfg_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          cfg_ready_q <= 1'b1;
          pending_q   <= 1'b0;
          applied_q   <= 1'b0;
        end
      endcase
    end
  end

  // A bad address in the same write as the clear keeps the flag set
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (accept && bad_hit) begin
      err_q <= 1'b1;
    end else if (accept && clr_hit) begin
      err_q <= 1'b0;
    end
  end

  radial_zone_cfg_regfile #(
    .NO_ZONES (NO_ZONES)
  ) u_regfile (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .zone_we_i    (accept & zone_hit),
    .zone_i       (cfg_addr_i[7:2]),
    .fld_i        (cfg_addr_i[1:0]),
    .col_we_i     (accept & col_hit),
    .row_we_i     (accept & row_hit),
    .data_i       (cfg_data_i),
    .apply_i      (state_q == ST_APPLY),
    .c_o          (c_o),
    .z_o          (z_o),
    .z_min_o      (z_min_o),
    .r_squared_o  (r_squared_o),
    .col_center_o (col_center_o),
    .row_center_o (row_center_o)
  );

  assign cfg_ready_o = cfg_ready_q;
  assign pending_o   = pending_q;
  assign applied_o   = applied_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: doc/radial_zone_cfg_writer.md
RADIAL_ZONE_CFG_WRITER -- requirements
Module: radial_zone_cfg_writer

Interface
REQ-001 SHALL have parameters, one per line:
- NO_ZONES, 1, number of radial zones (1..60)
- FRAME_START_GATED, 1, 1 = commit applies at next frame start; 0 = commit applies on next cycle
REQ-002 SHALL have ports, one per line:
- clk_i  in  1  sole clock
- rst_ni  in  1  asynchronous active-low reset
- cfg_valid_i  in  1  config write request
- cfg_ready_o  out  1  write accepted when cfg_valid_i & cfg_ready_o
- cfg_addr_i  in  8  register address
- cfg_data_i  in  18  write data
- valid_i  in  1  pixel-stream valid (frame-start snoop)
- col_i  in  16  pixel column
- row_i  in  16  pixel row
- c_o  out  16 x NO_ZONES  active confidence thresholds
- z_o  out  16 x NO_ZONES  active max-depth thresholds
- z_min_o  out  16 x NO_ZONES  active min-depth thresholds
- r_squared_o  out  18 x NO_ZONES  active squared radii
- col_center_o  out  16  active centre column
- row_center_o  out  16  active centre row
- pending_o  out  1  commit armed, not yet applied
- applied_o  out  1  one-cycle pulse on shadow-to-active copy
- err_o  out  1  sticky bad-address flag

Function
REQ-003 Address map SHALL be: addr = 4*z + f for z < NO_ZONES, where f=0 c, f=1 z, f=2 z_min, f=3 r_squared; 0xF0 col_center; 0xF1 row_center; 0xFE clear err; 0xFF commit.
REQ-004 Accepted writes SHALL update shadow registers only; 16-bit fields take cfg_data_i[15:0], r_squared takes all 18 bits.
REQ-005 Active outputs SHALL be registered and change only in the APPLY cycle.
REQ-006 FSM SHALL have states IDLE, PENDING, APPLY; IDLE->PENDING on accepted commit; PENDING->APPLY on frame start (when FRAME_START_GATED=1) or unconditionally next cycle (when 0); APPLY->IDLE after one cycle.
REQ-007 Frame start SHALL be valid_i & col_i==0 & row_i==0, sampled on the clock edge.
REQ-008 cfg_ready_o SHALL be 1 in IDLE and 0 in PENDING and APPLY, so the shadow cannot change while a commit is outstanding.
REQ-009 A frame start in the same cycle as the accepted commit SHALL NOT trigger APPLY; the next frame start does.
REQ-010 In APPLY, all shadow fields SHALL be copied to active outputs atomically in one edge; applied_o SHALL be high for exactly that cycle.
REQ-011 pending_o SHALL be 1 exactly while in PENDING.
REQ-012 A write to an unmapped address, including zone index >= NO_ZONES, SHALL be accepted, leave shadow unchanged and set err_o.
REQ-013 A write to 0xFE SHALL clear err_o; if a bad-address write coincides with the clear, the set wins.
REQ-014 Write-to-active latency SHALL be: commit accept at edge N -> outputs change at edge N+2 (ungated), or at edge F+1 where F is the first qualifying frame-start edge after N (gated).

Reset
REQ-015 On rst_ni low, state SHALL become IDLE asynchronously.
REQ-016 On reset, shadow and active SHALL be c=0x0000, z=0xFFFF, z_min=0x0000, r_squared=0x3FFFF and centres=0, giving a pass-through filter.
REQ-017 On reset, pending_o, applied_o and err_o SHALL be 0 and cfg_ready_o SHALL be 1.
REQ-018 Reset asserted while in PENDING SHALL discard the armed commit and shadow contents.

Structure
REQ-019 A shared package SHALL hold the field-offset constants, the 0xF0/0xF1/0xFE/0xFF addresses, the reset-value constants and the FSM state enum.
REQ-020 One sub-module, radial_zone_cfg_regfile, SHALL hold the shadow/active register pair with load and apply strobes; this block owns decode and the FSM.

Verification
REQ-021 Reset -> all outputs at REQ-016/REQ-017 values.
REQ-022 Gated mode: write zone0 c=0x3C00 and commit, no frame start for 20 cycles -> c_o[0] stays 0, pending_o=1, cfg_ready_o=0; frame start -> c_o[0]=0x3C00 one edge later, applied_o pulses once.
REQ-023 Commit in the same cycle as a frame start -> no apply; the following frame start applies.
REQ-024 NO_ZONES=2: write addr 0x08 -> err_o=1, shadow unchanged; write 0xFE -> err_o=0.
REQ-025 r_squared write 0x2ABCD then commit (ungated) -> r_squared_o[0]=0x2ABCD two edges after the commit accept.
REQ-026 rst_ni pulsed low in PENDING -> IDLE; a later frame start leaves the reset values on the outputs.
